// File: rtl/sym_error_counter.sv
// ============================================================================
// Module   : sym_error_counter
// Brief    : Symbol error counter comparing received symbols against a
//            delay-aligned transmit reference over a fixed window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sym_error_counter #(
    parameter int SYM_W     = 2,
    parameter int MAX_DELAY = 31,
    parameter int DELAY_W   = 5,
    parameter int CNT_W     = 22,
    parameter int WINDOW    = 4194303
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic [SYM_W-1:0]   ref_sym,
    input  logic [SYM_W-1:0]   rx_sym,
    input  logic [DELAY_W-1:0] delay,
    input  logic               start,
    input  logic               continuous,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   sym_count
);

    localparam logic [CNT_W-1:0] c_window = CNT_W'(WINDOW);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FLUSH   = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    logic [DELAY_W-1:0] r_delay_q;
    logic [DELAY_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0]   r_sym_cnt;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_err_count;
    logic [CNT_W-1:0]   r_sym_count;
    logic [SYM_W-1:0]   r_dline [MAX_DELAY];

    logic [SYM_W-1:0]   w_aligned;
    logic               w_mismatch;
    logic [CNT_W-1:0]   w_sym_next;
    logic [CNT_W-1:0]   w_err_next;

    // Reference delay line shifts on every symbol enable regardless of state
    generate
        for (genvar gi = 0; gi < MAX_DELAY; gi++) begin : g_dline
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset)
                        r_dline[gi] <= '0;
                    else if (clk_en)
                        r_dline[gi] <= ref_sym;
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset)
                        r_dline[gi] <= '0;
                    else if (clk_en)
                        r_dline[gi] <= r_dline[gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        w_aligned = ref_sym;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (r_delay_q == DELAY_W'(i + 1))
                w_aligned = r_dline[i];
        end
    end

    assign w_mismatch = (rx_sym != w_aligned);
    assign w_sym_next = r_sym_cnt + CNT_W'(1);
    assign w_err_next = r_err_cnt + CNT_W'(w_mismatch);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_delay_q   <= '0;
            r_flush_cnt <= '0;
            r_sym_cnt   <= '0;
            r_err_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_count <= '0;
            r_sym_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= '0;
                        r_sym_cnt   <= '0;
                        r_err_cnt   <= '0;
                        r_delay_q   <= delay;
                        r_busy      <= 1'b1;
                    end
                end
                // Wait until the selected delay stage holds post-start data
                S_FLUSH: begin
                    if (r_flush_cnt == r_delay_q)
                        r_state <= S_MEASURE;
                    else if (clk_en)
                        r_flush_cnt <= r_flush_cnt + DELAY_W'(1);
                end
                S_MEASURE: begin
                    if (clk_en) begin
                        if (w_sym_next == c_window) begin
                            r_sym_count <= c_window;
                            r_err_count <= w_err_next;
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_sym_cnt <= w_sym_next;
                            r_err_cnt <= w_err_next;
                        end
                    end
                end
                S_DONE: begin
                    if (continuous || start) begin
                        r_sym_cnt <= '0;
                        r_err_cnt <= '0;
                        r_state   <= S_MEASURE;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err_count = r_err_count;
    assign sym_count = r_sym_count;

endmodule

`default_nettype wire

// File: tb/tb_sym_error_counter.sv
// ============================================================================
// Module   : tb_sym_error_counter
// Brief    : Directed/randomized bench for sym_error_counter with a
//            history-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sym_error_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_en = 1'b0;
    logic [1:0]  ref_sym = '0;
    logic [1:0]  rx_sym = '0;
    logic [4:0]  delay = '0;
    logic        start16 = 1'b0;
    logic        start8 = 1'b0;
    logic        start1 = 1'b0;
    logic        continuous = 1'b0;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [21:0] errc0, errc1, errc2;
    logic [21:0] symc0, symc1, symc2;

    sym_error_counter #(.SYM_W(2), .MAX_DELAY(31), .DELAY_W(5), .CNT_W(22), .WINDOW(16)) u_w16 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .ref_sym(ref_sym), .rx_sym(rx_sym),
        .delay(delay), .start(start16), .continuous(continuous),
        .busy(busy_v[0]), .done(done_v[0]), .err_count(errc0), .sym_count(symc0));

    sym_error_counter #(.SYM_W(2), .MAX_DELAY(31), .DELAY_W(5), .CNT_W(22), .WINDOW(8)) u_w8 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .ref_sym(ref_sym), .rx_sym(rx_sym),
        .delay(delay), .start(start8), .continuous(continuous),
        .busy(busy_v[1]), .done(done_v[1]), .err_count(errc1), .sym_count(symc1));

    sym_error_counter #(.SYM_W(2), .MAX_DELAY(31), .DELAY_W(5), .CNT_W(22), .WINDOW(1)) u_w1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .ref_sym(ref_sym), .rx_sym(rx_sym),
        .delay(delay), .start(start1), .continuous(continuous),
        .busy(busy_v[2]), .done(done_v[2]), .err_count(errc2), .sym_count(symc2));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt [3] = '{0, 0, 0};
    int last_done_idx [3] = '{-1, -1, -1};
    logic [1:0] h_ref [$];
    logic [1:0] h_rx  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; any done pulse is attributed to the given enable index
    task automatic tick_mon(input int idx);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (done_v[k] === 1'b1) begin
                done_cnt[k]++;
                last_done_idx[k] = idx;
            end
        end
    endtask

    task automatic sym(input logic [1:0] r, input logic [1:0] x);
        int idx;
        idx = h_ref.size();
        clk_en  = 1'b1;
        ref_sym = r;
        rx_sym  = x;
        h_ref.push_back(r);
        h_rx.push_back(x);
        tick_mon(idx);
        clk_en = 1'b0;
        repeat (3) tick_mon(-1);
    endtask

    task automatic pulse(input int which);
        start16 = (which == 0);
        start8  = (which == 1);
        start1  = (which == 2);
        tick_mon(-1);
        start16 = 1'b0;
        start8  = 1'b0;
        start1  = 1'b0;
        tick_mon(-1);
        tick_mon(-1);
    endtask

    // Errors over n measured symbols starting at enable s, reference delayed by d enables
    function automatic int model_err(input int s, input int d, input int n);
        int c;
        c = 0;
        for (int e = s; e < s + n; e++)
            if (h_rx[e] !== h_ref[e - d]) c++;
        return c;
    endfunction

    function automatic logic [1:0] rsym();
        return 2'($urandom_range(0, 3));
    endfunction

    initial begin
        int s, d0, cnt, w, pos;
        int p1, p2;
        logic [1:0] r, x, a;
        cnt = 0;
        p1 = 0;
        p2 = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy_v[0]}, 32'd0);
        check("rst_done", {31'd0, done_v[0]}, 32'd0);
        check("rst_err", {10'd0, errc0}, 32'd0);
        check("rst_sym", {10'd0, symc0}, 32'd0);
        check("rst_busy1", {31'd0, busy_v[2]}, 32'd0);
        check("rst_sym1", {10'd0, symc2}, 32'd0);
        reset = 1'b1;
        tick_mon(-1);

        // Matched streams, no delay
        delay = 5'd0;
        pulse(0);
        s = h_ref.size();
        d0 = done_cnt[0];
        for (int i = 0; i < 16; i++) begin
            r = rsym();
            sym(r, r);
            if (i == 14) check("t1_busy", {31'd0, busy_v[0]}, 32'd1);
        end
        check("t1_done_at", last_done_idx[0], s + 15);
        check("t1_pulses", done_cnt[0] - d0, 1);
        check("t1_err", {10'd0, errc0}, model_err(s, 0, 16));
        check("t1_sym", {10'd0, symc0}, 32'd16);
        check("t1_idle", {31'd0, busy_v[0]}, 32'd0);

        // Counting reference, rx lags by 3 symbols; try delay 3 then 2
        for (int dl = 3; dl >= 2; dl--) begin
            delay = 5'(dl);
            pulse(0);
            s = h_ref.size() + dl;
            for (int i = 0; i < dl + 16; i++) begin
                r = 2'(cnt % 4);
                cnt++;
                x = (h_ref.size() >= 3) ? h_ref[h_ref.size() - 3] : 2'd0;
                sym(r, x);
            end
            check("t2_done_at", last_done_idx[0], s + 15);
            check("t2_err", {10'd0, errc0}, model_err(s, dl, 16));
        end

        // Five forced mismatches including first and last symbol
        delay = 5'd0;
        pulse(0);
        s = h_ref.size();
        d0 = done_cnt[0];
        for (int i = 0; i < 16; i++) begin
            r = rsym();
            x = (i == 0 || i == 3 || i == 7 || i == 11 || i == 15) ? ~r : r;
            sym(r, x);
        end
        check("t3_done_at", last_done_idx[0], s + 15);
        check("t3_pulses", done_cnt[0] - d0, 1);
        check("t3_err", {10'd0, errc0}, model_err(s, 0, 16));

        // Continuous mode, three back-to-back windows of 8 with delay 1
        continuous = 1'b1;
        delay = 5'd1;
        pulse(1);
        s = h_ref.size() + 1;
        d0 = done_cnt[1];
        sym(rsym(), rsym());
        for (int j = 0; j < 24; j++) begin
            w = j / 8;
            pos = j % 8;
            if (pos == 0) begin
                p1 = $urandom_range(0, 7);
                p2 = (p1 + 1 + $urandom_range(0, 6)) % 8;
            end
            if (j == 20) continuous = 1'b0;
            r = rsym();
            a = h_ref[h_ref.size() - 1];
            x = (pos == p1 || pos == p2) ? ~a : a;
            sym(r, x);
            if (pos == 7) begin
                check("t4_done_at", last_done_idx[1], s + j);
                check("t4_err", {10'd0, errc1}, model_err(s + w * 8, 1, 8));
                check("t4_sym", {10'd0, symc1}, 32'd8);
            end
        end
        check("t4_pulses", done_cnt[1] - d0, 3);
        check("t4_idle", {31'd0, busy_v[1]}, 32'd0);

        // Reset mid-measure, then ignored restart while busy
        delay = 5'd0;
        pulse(0);
        for (int i = 0; i < 10; i++) sym(rsym(), rsym());
        reset = 1'b0;
        #1;
        check("t5_busy", {31'd0, busy_v[0]}, 32'd0);
        check("t5_done", {31'd0, done_v[0]}, 32'd0);
        check("t5_err", {10'd0, errc0}, 32'd0);
        check("t5_sym", {10'd0, symc0}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick_mon(-1);
        pulse(0);
        s = h_ref.size();
        d0 = done_cnt[0];
        for (int i = 0; i < 5; i++) sym(rsym(), rsym());
        delay = 5'd7;
        start16 = 1'b1;
        tick_mon(-1);
        start16 = 1'b0;
        tick_mon(-1);
        check("t5_still_busy", {31'd0, busy_v[0]}, 32'd1);
        for (int i = 0; i < 11; i++) sym(rsym(), rsym());
        check("t5_done_at", last_done_idx[0], s + 15);
        check("t5_pulses", done_cnt[0] - d0, 1);
        check("t5_win_err", {10'd0, errc0}, model_err(s, 0, 16));
        check("t5_win_sym", {10'd0, symc0}, 32'd16);

        // Window of one symbol behind the maximum alignment delay
        for (int m = 0; m < 2; m++) begin
            delay = 5'd31;
            pulse(2);
            s = h_ref.size() + 31;
            d0 = done_cnt[2];
            for (int i = 0; i < 31; i++) sym(rsym(), rsym());
            check("t6_flush_busy", {31'd0, busy_v[2]}, 32'd1);
            check("t6_no_early_done", done_cnt[2] - d0, 0);
            r = rsym();
            a = h_ref[h_ref.size() - 31];
            x = (m == 1) ? ~a : a;
            sym(r, x);
            check("t6_done_at", last_done_idx[2], s);
            check("t6_err", {10'd0, errc2}, model_err(s, 31, 1));
            check("t6_sym", {10'd0, symc2}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
